// File: rtl/oldland_mem_stage.sv
// Memory stage: drives the data bus with a req/ack handshake, steers byte lanes,
// extracts load data and forwards results to writeback; stalls upstream while busy.
module oldland_mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_load,
  input  logic        mem_store,
  input  logic [1:0]  mem_width,
  input  logic [31:0] mar,
  input  logic [31:0] mdr,
  input  logic [31:0] wr_val,
  input  logic        wr_result,
  input  logic [3:0]  rd_sel,
  input  logic        i_valid,
  input  logic [31:0] pc_plus_4,
  output logic [31:0] d_addr,
  output logic [3:0]  d_bytesel,
  output logic [31:0] d_wr_val,
  output logic        d_wr_en,
  output logic        d_access,
  input  logic        d_ack,
  input  logic        d_error,
  input  logic [31:0] d_data,
  output logic [31:0] wr_val_out,
  output logic        wr_result_out,
  output logic [3:0]  rd_sel_out,
  output logic        i_valid_out,
  output logic [31:0] pc_plus_4_out,
  output logic        busy,
  output logic        data_abort
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [7:0] TO_LAST = 8'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic [7:0]  count;
  logic        mem_op, aligned, start, misaligned, term_ok, term_abort, timeout_hit;

  logic        load_p1;
  logic [1:0]  width_p1;
  logic [1:0]  off_p1;
  logic        wr_result_p1;
  logic [3:0]  rd_sel_p1;
  logic [31:0] wr_val_p1;
  logic [31:0] pc_p1;

  function automatic logic is_aligned(input logic [1:0] w, input logic [1:0] off);
    case (w)
      2'b00:   return 1'b1;
      2'b01:   return ~off[0];
      default: return off == 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_sel(input logic [1:0] w, input logic [1:0] off);
    case (w)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_rep(input logic [1:0] w, input logic [31:0] data);
    case (w)
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0] w, input logic [1:0] off,
                                               input logic [31:0] data);
    logic [31:0] sh;
    sh = data >> {off, 3'b000};
    case (w)
      2'b00:   return {24'h0, sh[7:0]};
      2'b01:   return {16'h0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign mem_op  = i_valid & (mem_load | mem_store);
  assign aligned = is_aligned(mem_width, mar[1:0]);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (count == TO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // The terminating WAIT cycle drops busy so upstream advances on that same edge.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    start      = 1'b0;
    misaligned = 1'b0;
    term_ok    = 1'b0;
    term_abort = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_op) begin
          if (aligned) begin
            start      = 1'b1;
            busy       = 1'b1;
            state_next = S_WAIT;
          end else begin
            misaligned = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (d_error)          term_abort = 1'b1;
        else if (d_ack)       term_ok    = 1'b1;
        else if (timeout_hit) term_abort = 1'b1;
        busy = ~(term_ok | term_abort);
        if (term_ok | term_abort) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Request capture (p1): only consumed when the transaction terminates.
  always_ff @(posedge clk) begin
    if (start) begin
      load_p1      <= mem_load & ~mem_store;
      width_p1     <= mem_width;
      off_p1       <= mar[1:0];
      wr_result_p1 <= wr_result;
      rd_sel_p1    <= rd_sel;
      wr_val_p1    <= wr_val;
      pc_p1        <= pc_plus_4;
    end
  end

  // Bus and writeback outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_addr        <= '0;
      d_bytesel     <= '0;
      d_wr_val      <= '0;
      d_wr_en       <= 1'b0;
      d_access      <= 1'b0;
      wr_val_out    <= '0;
      wr_result_out <= 1'b0;
      rd_sel_out    <= '0;
      i_valid_out   <= 1'b0;
      pc_plus_4_out <= '0;
      data_abort    <= 1'b0;
      count         <= '0;
    end else begin
      data_abort <= 1'b0;
      case (state)
        S_IDLE: begin
          count <= '0;
          if (start) begin
            d_access      <= 1'b1;
            d_addr        <= {mar[31:2], 2'b00};
            d_bytesel     <= byte_sel(mem_width, mar[1:0]);
            d_wr_val      <= store_rep(mem_width, mdr);
            d_wr_en       <= mem_store;
            wr_result_out <= 1'b0;
            i_valid_out   <= 1'b0;
          end else begin
            wr_val_out    <= wr_val;
            rd_sel_out    <= rd_sel;
            pc_plus_4_out <= pc_plus_4;
            i_valid_out   <= i_valid;
            wr_result_out <= wr_result & ~misaligned;
            data_abort    <= misaligned;
          end
        end
        S_WAIT: begin
          if (term_ok | term_abort) begin
            d_access      <= 1'b0;
            d_wr_en       <= 1'b0;
            count         <= '0;
            i_valid_out   <= 1'b1;
            rd_sel_out    <= rd_sel_p1;
            pc_plus_4_out <= pc_p1;
            if (term_ok) begin
              wr_val_out    <= load_p1 ? load_extract(width_p1, off_p1, d_data) : wr_val_p1;
              wr_result_out <= load_p1 & wr_result_p1;
            end else begin
              data_abort    <= 1'b1;
              wr_result_out <= 1'b0;
            end
          end else begin
            count <= count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_oldland_mem_stage.sv
// Directed bench for oldland_mem_stage: vector tables for single transactions
// plus hand sequences for timeout, reset during a transaction and back-to-back ops.
module tb_oldland_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_load, mem_store;
  logic [1:0]  mem_width;
  logic [31:0] mar, mdr, wr_val, pc_plus_4;
  logic        wr_result, i_valid;
  logic [3:0]  rd_sel;
  logic [31:0] d_addr, d_wr_val, d_data;
  logic [3:0]  d_bytesel;
  logic        d_wr_en, d_access, d_ack, d_error;
  logic [31:0] wr_val_out, pc_plus_4_out;
  logic        wr_result_out, i_valid_out, busy, data_abort;
  logic [3:0]  rd_sel_out;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  oldland_mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_load(mem_load), .mem_store(mem_store), .mem_width(mem_width),
    .mar(mar), .mdr(mdr), .wr_val(wr_val), .wr_result(wr_result),
    .rd_sel(rd_sel), .i_valid(i_valid), .pc_plus_4(pc_plus_4),
    .d_addr(d_addr), .d_bytesel(d_bytesel), .d_wr_val(d_wr_val),
    .d_wr_en(d_wr_en), .d_access(d_access), .d_ack(d_ack),
    .d_error(d_error), .d_data(d_data),
    .wr_val_out(wr_val_out), .wr_result_out(wr_result_out),
    .rd_sel_out(rd_sel_out), .i_valid_out(i_valid_out),
    .pc_plus_4_out(pc_plus_4_out), .busy(busy), .data_abort(data_abort)
  );

  typedef struct {
    logic ld, st; logic [1:0] w; logic [31:0] mar, wv; logic wr;
    logic [3:0] rd; logic iv; logic [31:0] pc;
    logic e_abort, e_wr, e_iv;
  } idle_vec_t;

  typedef struct {
    logic ld, st; logic [1:0] w; logic [31:0] mar, mdr, wv; logic wr;
    logic [3:0] rd; logic [31:0] pc;
    int n_wait; logic err, ack; logic [31:0] ddata;
    logic [31:0] e_addr; logic [3:0] e_bsel; logic [31:0] e_dwv; logic e_wen;
    logic [31:0] e_wvo; logic e_wro, e_abort;
  } bus_vec_t;

  idle_vec_t itab[6];
  bus_vec_t  btab[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic set_idle();
    mem_load = 1'b0; mem_store = 1'b0; mem_width = 2'b00;
    mar = '0; mdr = '0; wr_val = '0; wr_result = 1'b0;
    rd_sel = '0; i_valid = 1'b0; pc_plus_4 = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic run_idle(input idle_vec_t v, input int idx);
    string t;
    t = $sformatf("idle%0d", idx);
    mem_load = v.ld; mem_store = v.st; mem_width = v.w; mar = v.mar;
    wr_val = v.wv; wr_result = v.wr; rd_sel = v.rd; i_valid = v.iv; pc_plus_4 = v.pc;
    #1;
    chk({t, " busy"}, 32'(busy), 32'(1'b0));
    step();
    chk({t, " d_access"},      32'(d_access), 32'(1'b0));
    chk({t, " data_abort"},    32'(data_abort), 32'(v.e_abort));
    chk({t, " wr_result_out"}, 32'(wr_result_out), 32'(v.e_wr));
    chk({t, " i_valid_out"},   32'(i_valid_out), 32'(v.e_iv));
    chk({t, " rd_sel_out"},    32'(rd_sel_out), 32'(v.rd));
    chk({t, " wr_val_out"},    wr_val_out, v.wv);
    chk({t, " pc_plus_4_out"}, pc_plus_4_out, v.pc);
  endtask

  task automatic run_bus(input bus_vec_t v, input int idx);
    string t;
    int busy_cnt;
    logic held;
    t = $sformatf("bus%0d", idx);
    mem_load = v.ld; mem_store = v.st; mem_width = v.w; mar = v.mar; mdr = v.mdr;
    wr_val = v.wv; wr_result = v.wr; rd_sel = v.rd; i_valid = 1'b1; pc_plus_4 = v.pc;
    d_ack = 1'b0; d_error = 1'b0;
    #1;
    busy_cnt = busy ? 1 : 0;
    step();
    chk({t, " d_access"},  32'(d_access), 32'(1'b1));
    chk({t, " d_addr"},    d_addr, v.e_addr);
    chk({t, " d_bytesel"}, 32'(d_bytesel), 32'(v.e_bsel));
    chk({t, " d_wr_val"},  d_wr_val, v.e_dwv);
    chk({t, " d_wr_en"},   32'(d_wr_en), 32'(v.e_wen));
    chk({t, " bubble wr_result_out"}, 32'(wr_result_out), 32'(1'b0));
    chk({t, " bubble i_valid_out"},   32'(i_valid_out), 32'(1'b0));
    held = 1'b1;
    for (int k = 1; k <= v.n_wait; k++) begin
      if (k == v.n_wait) begin
        d_ack = v.ack; d_error = v.err; d_data = v.ddata;
      end
      #1;
      if (busy) busy_cnt++;
      if (d_access !== 1'b1 || d_addr !== v.e_addr || d_bytesel !== v.e_bsel ||
          d_wr_val !== v.e_dwv || d_wr_en !== v.e_wen) held = 1'b0;
      step();
    end
    d_ack = 1'b0; d_error = 1'b0;
    set_idle();
    chk({t, " busy cycles"},   32'(busy_cnt), 32'(v.n_wait));
    chk({t, " bus held"},      32'(held), 32'(1'b1));
    chk({t, " end d_access"},  32'(d_access), 32'(1'b0));
    chk({t, " data_abort"},    32'(data_abort), 32'(v.e_abort));
    chk({t, " wr_result_out"}, 32'(wr_result_out), 32'(v.e_wro));
    chk({t, " i_valid_out"},   32'(i_valid_out), 32'(1'b1));
    chk({t, " rd_sel_out"},    32'(rd_sel_out), 32'(v.rd));
    chk({t, " pc_plus_4_out"}, pc_plus_4_out, v.pc);
    if (v.ld && !v.err) chk({t, " wr_val_out"}, wr_val_out, v.e_wvo);
    step();
    chk({t, " abort cleared"}, 32'(data_abort), 32'(1'b0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen;

    //            ld st w      mar       wv        wr rd    iv pc        ab wr iv
    itab[0] = '{1'b0,1'b0,2'b00,32'h0,  32'h1234,1'b1,4'd3, 1'b1,32'h44, 1'b0,1'b1,1'b1};
    itab[1] = '{1'b1,1'b0,2'b10,32'h0,  32'h55,  1'b1,4'd5, 1'b0,32'h48, 1'b0,1'b1,1'b0};
    itab[2] = '{1'b1,1'b0,2'b10,32'h101,32'h66,  1'b1,4'd7, 1'b1,32'h4C, 1'b1,1'b0,1'b1};
    itab[3] = '{1'b0,1'b1,2'b01,32'h203,32'h77,  1'b1,4'd8, 1'b1,32'h50, 1'b1,1'b0,1'b1};
    itab[4] = '{1'b1,1'b0,2'b11,32'h102,32'h88,  1'b1,4'd9, 1'b1,32'h54, 1'b1,1'b0,1'b1};
    itab[5] = '{1'b0,1'b0,2'b00,32'h0,  32'h99,  1'b0,4'd10,1'b1,32'h58, 1'b0,1'b0,1'b1};

    btab[0] = '{1'b1,1'b0,2'b00,32'h102,32'h0,32'h0,1'b1,4'd2,32'h100, 3,1'b0,1'b1,32'hAABBCCDD,
                32'h100,4'b0100,32'h0,1'b0,32'h000000BB,1'b1,1'b0};
    btab[1] = '{1'b0,1'b1,2'b01,32'h206,32'hFFFF1234,32'hCAFE,1'b1,4'd4,32'h104, 1,1'b0,1'b1,32'h0,
                32'h204,4'b1100,32'h12341234,1'b1,32'h0,1'b0,1'b0};
    btab[2] = '{1'b1,1'b0,2'b10,32'h300,32'h0,32'h0,1'b1,4'd6,32'h108, 4,1'b0,1'b1,32'h89ABCDEF,
                32'h300,4'b1111,32'h0,1'b0,32'h89ABCDEF,1'b1,1'b0};
    btab[3] = '{1'b1,1'b0,2'b01,32'h102,32'h0,32'h0,1'b1,4'd1,32'h10C, 2,1'b0,1'b1,32'hAABBCCDD,
                32'h100,4'b1100,32'h0,1'b0,32'h0000AABB,1'b1,1'b0};
    btab[4] = '{1'b1,1'b0,2'b10,32'h400,32'h0,32'h0,1'b1,4'd11,32'h110, 2,1'b1,1'b1,32'h0,
                32'h400,4'b1111,32'h0,1'b0,32'h0,1'b0,1'b1};
    btab[5] = '{1'b0,1'b1,2'b00,32'h503,32'hA5,32'h0,1'b0,4'd12,32'h114, 1,1'b0,1'b1,32'h0,
                32'h500,4'b1000,32'hA5A5A5A5,1'b1,32'h0,1'b0,1'b0};
    btab[6] = '{1'b0,1'b1,2'b10,32'h600,32'h11223344,32'h0,1'b1,4'd13,32'h118, 3,1'b1,1'b0,32'h0,
                32'h600,4'b1111,32'h11223344,1'b1,32'h0,1'b0,1'b1};

    // Reset with live inputs and a stray ack
    rst_n = 1'b0;
    set_idle();
    wr_val = 32'hDEADBEEF; wr_result = 1'b1; rd_sel = 4'd15; i_valid = 1'b1; pc_plus_4 = 32'h80;
    d_ack = 1'b1; d_error = 1'b0; d_data = 32'h0;
    step(); step();
    chk("reset d_access",      32'(d_access), 32'(1'b0));
    chk("reset d_bytesel",     32'(d_bytesel), 32'(4'b0));
    chk("reset wr_val_out",    wr_val_out, 32'h0);
    chk("reset wr_result_out", 32'(wr_result_out), 32'(1'b0));
    chk("reset i_valid_out",   32'(i_valid_out), 32'(1'b0));
    chk("reset rd_sel_out",    32'(rd_sel_out), 32'(4'b0));
    chk("reset data_abort",    32'(data_abort), 32'(1'b0));
    chk("reset pc_plus_4_out", pc_plus_4_out, 32'h0);
    rst_n = 1'b1;
    d_ack = 1'b0;
    set_idle();
    step();

    for (int i = 0; i < 6; i++) run_idle(itab[i], i);
    for (int i = 0; i < 7; i++) run_bus(btab[i], i);

    // Timeout: no response at all
    mem_load = 1'b1; mem_width = 2'b10; mar = 32'h700; i_valid = 1'b1; wr_result = 1'b1; rd_sel = 4'd9;
    #1;
    step();
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (d_access) n++;
      step();
      if (data_abort) begin
        seen = 1'b1;
        break;
      end
    end
    set_idle();
    chk("timeout wait cycles",    32'(n), 32'(TO));
    chk("timeout data_abort",     32'(seen), 32'(1'b1));
    chk("timeout wr_result_out",  32'(wr_result_out), 32'(1'b0));
    chk("timeout i_valid_out",    32'(i_valid_out), 32'(1'b1));
    chk("timeout d_access",       32'(d_access), 32'(1'b0));
    step();

    // Reset while a transaction is outstanding
    mem_load = 1'b1; mem_width = 2'b10; mar = 32'h800; i_valid = 1'b1; wr_result = 1'b1; rd_sel = 4'd14;
    #1;
    step();
    chk("rstwait d_access before", 32'(d_access), 32'(1'b1));
    rst_n = 1'b0;
    step();
    chk("rstwait d_access",    32'(d_access), 32'(1'b0));
    chk("rstwait i_valid_out", 32'(i_valid_out), 32'(1'b0));
    rst_n = 1'b1;
    set_idle();
    d_ack = 1'b1; d_data = 32'h12345678;
    step(); step();
    chk("rstwait late ack abort",     32'(data_abort), 32'(1'b0));
    chk("rstwait late ack wr_result", 32'(wr_result_out), 32'(1'b0));
    chk("rstwait late ack i_valid",   32'(i_valid_out), 32'(1'b0));
    chk("rstwait late ack d_access",  32'(d_access), 32'(1'b0));
    d_ack = 1'b0;
    step();

    // Back-to-back: new request presented on the terminating edge
    mem_load = 1'b1; mem_width = 2'b00; mar = 32'h900; i_valid = 1'b1; wr_result = 1'b1; rd_sel = 4'd2;
    #1;
    step();
    d_ack = 1'b1; d_data = 32'h123456EE;
    step();
    d_ack = 1'b0;
    mem_width = 2'b01; mar = 32'hA02; rd_sel = 4'd3;
    #1;
    chk("b2b gap d_access",  32'(d_access), 32'(1'b0));
    chk("b2b gap busy",      32'(busy), 32'(1'b1));
    chk("b2b first wr_val",  wr_val_out, 32'h000000EE);
    step();
    chk("b2b second d_access",  32'(d_access), 32'(1'b1));
    chk("b2b second d_addr",    d_addr, 32'hA00);
    chk("b2b second d_bytesel", 32'(d_bytesel), 32'(4'b1100));
    d_ack = 1'b1; d_data = 32'hAABBCCDD;
    step();
    d_ack = 1'b0;
    set_idle();
    chk("b2b second wr_val",    wr_val_out, 32'h0000AABB);
    chk("b2b second wr_result", 32'(wr_result_out), 32'(1'b1));
    chk("b2b second rd_sel",    32'(rd_sel_out), 32'(4'd3));
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/oldland_mem_stage.md
Name: oldland_mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the registered memory request (MAR, MDR, width, load/store) and the writeback candidate (value, rd select, write enable).
- Performs the data-bus transaction with a req/ack handshake, lane steering and load extraction, then presents results to writeback.
- Stalls the pipeline while a transaction is outstanding and raises data_abort on misalignment, bus error or timeout.

Parameters:
- TIMEOUT_CYCLES, 255: cycles to wait in WAIT before aborting; 0 disables the timeout. Counter width 8 bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- mem_load  in  1  load request from execute
- mem_store  in  1  store request from execute
- mem_width  in  2  access width: 00 = byte, 01 = half, 10 = word; 11 treated as word
- mar  in  32  byte address
- mdr  in  32  store data, right-justified
- wr_val  in  32  non-load writeback value
- wr_result  in  1  rd write enable
- rd_sel  in  4  destination register
- i_valid  in  1  instruction valid
- pc_plus_4  in  32  pass-through
- d_addr  out  32  bus address, bits [1:0] = 0
- d_bytesel  out  4  byte-lane enables
- d_wr_val  out  32  bus write data
- d_wr_en  out  1  write strobe qualifier
- d_access  out  1  bus request
- d_ack  in  1  transaction complete
- d_error  in  1  transaction failed
- d_data  in  32  bus read data
- wr_val_out  out  32  writeback value
- wr_result_out  out  1  writeback enable
- rd_sel_out  out  4  writeback register
- i_valid_out  out  1  valid to writeback
- pc_plus_4_out  out  32  pass-through
- busy  out  1  stall request to upstream stages
- data_abort  out  1  one-cycle abort pulse

Behaviour:
- **Reset** (rst_n low at posedge): state = IDLE; all outputs 0; timeout counter 0. A d_ack arriving after reset is ignored.
- **States:** IDLE, WAIT.
- **IDLE, no memory op** (mem_load = mem_store = 0 or i_valid = 0): next edge registers wr_val, wr_result, rd_sel, i_valid and pc_plus_4 to the outputs. Latency is 1 cycle; busy = 0.
- **IDLE, aligned memory op:** busy asserts combinationally in the same cycle. Next edge:
  - d_access = 1, d_addr = {mar[31:2], 2'b00}, d_wr_en = mem_store.
  - Inputs are captured internally; state goes to WAIT; writeback outputs are a bubble (wr_result_out = 0, i_valid_out = 0).
  - Upstream holds its inputs while busy = 1.
- **Alignment:** byte is always aligned; half requires mar[0] = 0; word requires mar[1:0] = 0.
- **IDLE, misaligned op:** no bus access is made.
  - Next edge: data_abort = 1 for one cycle, wr_result_out = 0, i_valid_out = 1, state stays IDLE.
  - busy = 0 throughout.
- **Byte select:**
  - byte: 4'b0001 << mar[1:0]
  - half: 4'b0011 << mar[1:0]
  - word: 4'b1111
- **Store data replication:**
  - byte: {4{mdr[7:0]}}
  - half: {2{mdr[15:0]}}
  - word: mdr
- **WAIT:** d_access, d_addr, d_bytesel, d_wr_val and d_wr_en are held stable. busy = 1 in every WAIT cycle except the terminating one, where busy = 0 combinationally so upstream advances on that same edge.
- **Termination priority**, per WAIT cycle:
  - d_error → abort.
  - Else d_ack → success.
  - Else counter == TIMEOUT_CYCLES - 1 (when TIMEOUT_CYCLES ≠ 0) → abort.
  - Else the counter increments.
- **Success edge:** d_access = 0, state = IDLE, i_valid_out = 1, rd_sel_out = captured rd_sel.
  - Load: wr_val_out = (d_data >> 8*mar[1:0]), zero-extended and masked to width; wr_result_out = captured wr_result.
  - Store: wr_result_out = 0.
- **Abort edge:** d_access = 0, data_abort = 1 for exactly one cycle, wr_result_out = 0, i_valid_out = 1, state = IDLE, counter cleared.
- **Back-to-back ops:** a new request presented on the terminating edge is accepted in the following IDLE cycle. There is at least one IDLE cycle between transactions.
- **Ack timing:** d_ack in the same cycle d_access first rises counts, giving minimum 2-cycle memory latency. d_ack or d_error while IDLE is ignored.
- **Reset mid-WAIT:** drops d_access the next edge; the request is discarded with no abort.

Test Plan:
- **Pass-through:** wr_val = 0x1234, rd_sel = 3, wr_result = 1, no mem op → one cycle later wr_val_out = 0x1234, rd_sel_out = 3, wr_result_out = 1, busy never high.
- **Byte load:** mar = 0x102, width 00, d_data = 0xAABBCCDD, ack after 3 cycles → d_addr = 0x100, d_bytesel = 0100, busy for 3 cycles, wr_val_out = 0x000000BB.
- **Half store:** mar = 0x206, mdr = 0xFFFF1234 → d_bytesel = 1100, d_wr_val = 0x12341234, d_wr_en = 1, wr_result_out = 0.
- **Misaligned word load:** mar = 0x101 → no d_access, data_abort pulses 1 cycle, wr_result_out = 0.
- **Bus error:** d_error and d_ack asserted together in WAIT → data_abort = 1, no register write. With TIMEOUT_CYCLES = 4 and no ack → abort after exactly 4 WAIT cycles.
- **Reset mid-WAIT:** rst_n low during WAIT → d_access = 0 next edge; a later ack produces no writeback or abort.
